// File: rtl/mor1kx_ctrl_spr_access_cappuccino_pkg.sv
// Shared definitions for the ctrl-stage SPR access sequencer:
// state encodings, SPR address width and the group field position.
package mor1kx_ctrl_spr_access_cappuccino_pkg;

    localparam int SPR_ADDR_W    = 16;
    localparam int SPR_GROUP_MSB = 15;
    localparam int SPR_GROUP_LSB = 11;

    typedef enum logic [1:0] {
        OR1K_SPRACC_IDLE   = 2'd0,
        OR1K_SPRACC_ACCESS = 2'd1,
        OR1K_SPRACC_DONE   = 2'd2
    } spracc_state_t;

    function automatic logic [SPR_GROUP_MSB-SPR_GROUP_LSB:0] spr_group(
        input logic [SPR_ADDR_W-1:0] addr);
        return addr[SPR_GROUP_MSB:SPR_GROUP_LSB];
    endfunction

endpackage

// File: rtl/mor1kx_ctrl_spr_access_cappuccino_if.sv
// SPR bus between the ctrl-stage sequencer (master) and the SPR slaves.
// Handshake: stb raised with addr/we/dat stable; they stay unchanged until the
// slave returns ack (dat_i valid in that cycle). ack without stb is ignored.
interface mor1kx_ctrl_spr_access_cappuccino_if
    import mor1kx_ctrl_spr_access_cappuccino_pkg::*;
    #(parameter int W = 32);

    logic [SPR_ADDR_W-1:0] spr_bus_addr_o;
    logic                  spr_bus_we_o;
    logic                  spr_bus_stb_o;
    logic [W-1:0]          spr_bus_dat_o;
    logic [W-1:0]          spr_bus_dat_i;
    logic                  spr_bus_ack_i;

    modport master (
        output spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
        input  spr_bus_dat_i, spr_bus_ack_i
    );

    modport slave (
        input  spr_bus_addr_o, spr_bus_we_o, spr_bus_stb_o, spr_bus_dat_o,
        output spr_bus_dat_i, spr_bus_ack_i
    );

endinterface

// File: rtl/mor1kx_ctrl_spr_access_cappuccino_spr_timeout.sv
// SPR access watchdog: 8-bit cycle counter; expired flags the cycle whose
// increment would reach LIMIT. Only instantiated with MOR1KX_SPR_TIMEOUT_EN.
module mor1kx_spr_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= 8'd0;
        else if (clr)
            r_cnt <= 8'd0;
        else if (en)
            r_cnt <= r_cnt + 8'd1;
    end

    assign expired = en && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/mor1kx_ctrl_spr_access_cappuccino.sv
// Ctrl-stage SPR access sequencer: turns a held mfspr/mtspr into one SPR bus
// transaction and a single-cycle ack. Optional watchdog: MOR1KX_SPR_TIMEOUT_EN.
module mor1kx_ctrl_spr_access_cappuccino
    import mor1kx_ctrl_spr_access_cappuccino_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_SPR_TIMEOUT   = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ctrl_op_mfspr_i,
    input  logic                            ctrl_op_mtspr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_rfb_i,
    input  logic                            supervisor_mode_i,
    input  logic                            pipeline_flush_i,
    mor1kx_ctrl_spr_access_cappuccino_if.master spr_bus,
    output logic                            ctrl_mfspr_ack_o,
    output logic                            ctrl_mtspr_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] mfspr_dat_o,
    output logic                            spr_timeout_o,
    output spracc_state_t                   o_dbg_state
);

    localparam int W = OPTION_OPERAND_WIDTH;

    spracc_state_t         r_state, w_state_nx;
    logic [SPR_ADDR_W-1:0] r_addr, w_addr_nx;
    logic                  r_we, w_we_nx;
    logic                  r_stb, w_stb_nx;
    logic [W-1:0]          r_dat, w_dat_nx;
    logic [W-1:0]          r_mfspr_dat, w_mfspr_dat_nx;
    logic                  r_mfspr_ack, w_mfspr_ack_nx;
    logic                  r_mtspr_ack, w_mtspr_ack_nx;
    logic                  r_timeout, w_timeout_nx;
    logic                  r_kill, w_kill_nx;
    logic                  w_expired;
    logic                  w_unused_bits;

`ifdef MOR1KX_SPR_TIMEOUT_EN
    mor1kx_spr_timeout #(.LIMIT(OPTION_SPR_TIMEOUT)) u_spr_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state != OR1K_SPRACC_ACCESS),
        .en      ((r_state == OR1K_SPRACC_ACCESS) && !spr_bus.spr_bus_ack_i),
        .expired (w_expired)
    );
    assign w_unused_bits = ^ctrl_alu_result_i[W-1:SPR_ADDR_W];
`else
    assign w_expired     = 1'b0;
    assign w_unused_bits = ^{ctrl_alu_result_i[W-1:SPR_ADDR_W], 8'(OPTION_SPR_TIMEOUT)};
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_we_nx        = r_we;
        w_stb_nx       = r_stb;
        w_dat_nx       = r_dat;
        w_mfspr_dat_nx = r_mfspr_dat;
        w_kill_nx      = r_kill;
        w_mfspr_ack_nx = 1'b0;
        w_mtspr_ack_nx = 1'b0;
        w_timeout_nx   = 1'b0;
        case (r_state)
            OR1K_SPRACC_IDLE: begin
                if ((ctrl_op_mfspr_i || ctrl_op_mtspr_i) && !pipeline_flush_i) begin
                    w_we_nx   = ctrl_op_mtspr_i;
                    w_kill_nx = 1'b0;
                    if (supervisor_mode_i) begin
                        w_state_nx = OR1K_SPRACC_ACCESS;
                        w_addr_nx  = ctrl_alu_result_i[SPR_ADDR_W-1:0];
                        w_dat_nx   = ctrl_rfb_i;
                        w_stb_nx   = 1'b1;
                    end else begin
                        // Unprivileged access completes immediately, reads as zero.
                        w_state_nx     = OR1K_SPRACC_DONE;
                        w_mfspr_dat_nx = '0;
                        w_mfspr_ack_nx = !ctrl_op_mtspr_i;
                        w_mtspr_ack_nx = ctrl_op_mtspr_i;
                    end
                end
            end
            OR1K_SPRACC_ACCESS: begin
                if (pipeline_flush_i)
                    w_kill_nx = 1'b1;
                if (spr_bus.spr_bus_ack_i || w_expired) begin
                    w_stb_nx = 1'b0;
                    if (r_kill || pipeline_flush_i) begin
                        // Killed op: let the bus cycle finish, report nothing.
                        w_state_nx = OR1K_SPRACC_IDLE;
                    end else begin
                        w_state_nx     = OR1K_SPRACC_DONE;
                        w_mfspr_ack_nx = !r_we;
                        w_mtspr_ack_nx = r_we;
                        if (spr_bus.spr_bus_ack_i) begin
                            if (!r_we)
                                w_mfspr_dat_nx = spr_bus.spr_bus_dat_i;
                        end else begin
                            w_mfspr_dat_nx = '0;
                            w_timeout_nx   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nx = OR1K_SPRACC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= OR1K_SPRACC_IDLE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_stb       <= 1'b0;
            r_dat       <= '0;
            r_mfspr_dat <= '0;
            r_mfspr_ack <= 1'b0;
            r_mtspr_ack <= 1'b0;
            r_timeout   <= 1'b0;
            r_kill      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_we        <= w_we_nx;
            r_stb       <= w_stb_nx;
            r_dat       <= w_dat_nx;
            r_mfspr_dat <= w_mfspr_dat_nx;
            r_mfspr_ack <= w_mfspr_ack_nx;
            r_mtspr_ack <= w_mtspr_ack_nx;
            r_timeout   <= w_timeout_nx;
            r_kill      <= w_kill_nx;
        end
    end

    assign spr_bus.spr_bus_addr_o = r_addr;
    assign spr_bus.spr_bus_we_o   = r_we;
    assign spr_bus.spr_bus_stb_o  = r_stb;
    assign spr_bus.spr_bus_dat_o  = r_dat;
    assign ctrl_mfspr_ack_o       = r_mfspr_ack;
    assign ctrl_mtspr_ack_o       = r_mtspr_ack;
    assign mfspr_dat_o            = r_mfspr_dat;
    assign spr_timeout_o          = r_timeout;
    assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_mor1kx_ctrl_spr_access_cappuccino.sv
// Directed bench for the ctrl-stage SPR access sequencer; inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_mor1kx_ctrl_spr_access_cappuccino;
    import mor1kx_ctrl_spr_access_cappuccino_pkg::*;

    localparam int W = 32;
`ifdef MOR1KX_SPR_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mfspr, mtspr, sup, flush;
    logic [W-1:0]  alu, rfb;
    logic          mfspr_ack, mtspr_ack, timeout;
    logic [W-1:0]  mfspr_dat;
    spracc_state_t dbg_state;

    int total = 0;
    int bad   = 0;

    mor1kx_ctrl_spr_access_cappuccino_if #(.W(W)) bus();

    mor1kx_ctrl_spr_access_cappuccino #(
        .OPTION_OPERAND_WIDTH (W),
        .OPTION_SPR_TIMEOUT   (TMO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ctrl_op_mfspr_i   (mfspr),
        .ctrl_op_mtspr_i   (mtspr),
        .ctrl_alu_result_i (alu),
        .ctrl_rfb_i        (rfb),
        .supervisor_mode_i (sup),
        .pipeline_flush_i  (flush),
        .spr_bus           (bus),
        .ctrl_mfspr_ack_o  (mfspr_ack),
        .ctrl_mtspr_ack_o  (mtspr_ack),
        .mfspr_dat_o       (mfspr_dat),
        .spr_timeout_o     (timeout),
        .o_dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        mfspr = 0; mtspr = 0; sup = 1; flush = 0; alu = '0; rfb = '0;
        bus.spr_bus_ack_i = 0; bus.spr_bus_dat_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_stb",   32'(bus.spr_bus_stb_o), 32'd0);
        chk("rst_acks",  32'({mfspr_ack, mtspr_ack, timeout}), 32'd0);
        chk("rst_dat",   mfspr_dat, 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(OR1K_SPRACC_IDLE));
        rst = 0;
        step();

        // mfspr 0x0011, slave acks in the first stb cycle
        mfspr = 1; alu = 32'hFFFF_0011;
        step();
        chk("t1_stb",  32'(bus.spr_bus_stb_o), 32'd1);
        chk("t1_addr", 32'(bus.spr_bus_addr_o), 32'h0011);
        chk("t1_we",   32'(bus.spr_bus_we_o), 32'd0);
        chk("t1_noack", 32'(mfspr_ack), 32'd0);
        bus.spr_bus_ack_i = 1; bus.spr_bus_dat_i = 32'hDEAD_BEEF;
        step();
        bus.spr_bus_ack_i = 0; mfspr = 0;
        chk("t1_ack",   32'({mfspr_ack, mtspr_ack}), 32'b10);
        chk("t1_stb0",  32'(bus.spr_bus_stb_o), 32'd0);
        chk("t1_dat",   mfspr_dat, 32'hDEAD_BEEF);
        step();
        chk("t1_ack1",  32'(mfspr_ack), 32'd0);
        chk("t1_idle",  32'(dbg_state), 32'(OR1K_SPRACC_IDLE));

        // stray ack outside ACCESS has no effect
        bus.spr_bus_ack_i = 1; bus.spr_bus_dat_i = 32'hFFFF_FFFF;
        step();
        bus.spr_bus_ack_i = 0;
        chk("stray_ack", 32'({bus.spr_bus_stb_o, mfspr_ack, mtspr_ack}), 32'd0);
        chk("stray_dat", mfspr_dat, 32'hDEAD_BEEF);

        // mtspr 0x2801 <= 0x12345678, ack after 5 stb cycles
        mtspr = 1; alu = 32'h0000_2801; rfb = 32'h1234_5678;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold", 32'({bus.spr_bus_stb_o, bus.spr_bus_we_o, mtspr_ack}), 32'b110);
            chk("t2_addr", 32'(bus.spr_bus_addr_o), 32'h2801);
            chk("t2_wdat", bus.spr_bus_dat_o, 32'h1234_5678);
            if (i == 4) bus.spr_bus_ack_i = 1;
            step();
        end
        bus.spr_bus_ack_i = 0; mtspr = 0;
        chk("t2_ack",  32'({mfspr_ack, mtspr_ack, bus.spr_bus_stb_o}), 32'b010);
        chk("t2_rdat", mfspr_dat, 32'hDEAD_BEEF);
        step();
        chk("t2_ack1", 32'(mtspr_ack), 32'd0);

        // unprivileged mfspr: no bus access, ack next cycle, data 0
        sup = 0; mfspr = 1; alu = 32'h0000_0011;
        step();
        chk("t3_stb", 32'(bus.spr_bus_stb_o), 32'd0);
        chk("t3_ack", 32'(mfspr_ack), 32'd1);
        chk("t3_dat", mfspr_dat, 32'd0);
        mfspr = 0; sup = 1;
        step();
        chk("t3_ack1", 32'({bus.spr_bus_stb_o, mfspr_ack}), 32'd0);

        // known read data before the flush test
        mfspr = 1; alu = 32'h20;
        step();
        bus.spr_bus_ack_i = 1; bus.spr_bus_dat_i = 32'hCAFE_F00D;
        step();
        bus.spr_bus_ack_i = 0; mfspr = 0;
        chk("t4_pre", mfspr_dat, 32'hCAFE_F00D);
        step();

        // flush in the 2nd of 4 ACCESS cycles; a new mfspr waits for IDLE
        mfspr = 1; alu = 32'h30;
        step();
        chk("t4_a1", 32'(bus.spr_bus_stb_o), 32'd1);
        step();
        flush = 1;
        step();
        flush = 0; alu = 32'h40;
        chk("t4_a3", 32'({bus.spr_bus_stb_o, bus.spr_bus_addr_o}), 32'h1_0030);
        step();
        bus.spr_bus_ack_i = 1; bus.spr_bus_dat_i = 32'h5555_5555;
        step();
        bus.spr_bus_ack_i = 0;
        chk("t4_noack", 32'({mfspr_ack, mtspr_ack, bus.spr_bus_stb_o}), 32'd0);
        chk("t4_dat",   mfspr_dat, 32'hCAFE_F00D);
        chk("t4_idle",  32'(dbg_state), 32'(OR1K_SPRACC_IDLE));
        step();
        chk("t4_restart", 32'({bus.spr_bus_stb_o, bus.spr_bus_addr_o}), 32'h1_0040);
        bus.spr_bus_ack_i = 1; bus.spr_bus_dat_i = 32'h0BAD_CAFE;
        step();
        bus.spr_bus_ack_i = 0; mfspr = 0;
        chk("t4_ack2", 32'(mfspr_ack), 32'd1);
        chk("t4_dat2", mfspr_dat, 32'h0BAD_CAFE);
        step();

        // both ops set: mtspr wins
        mfspr = 1; mtspr = 1; alu = 32'h70; rfb = 32'h1;
        step();
        chk("t5_we", 32'({bus.spr_bus_stb_o, bus.spr_bus_we_o}), 32'b11);
        bus.spr_bus_ack_i = 1;
        step();
        bus.spr_bus_ack_i = 0; mfspr = 0; mtspr = 0;
        chk("t5_ack", 32'({mfspr_ack, mtspr_ack}), 32'b01);
        step();

        // slave never acks
        mfspr = 1; alu = 32'h50;
        step();
`ifdef MOR1KX_SPR_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            chk("t6_wait", 32'({bus.spr_bus_stb_o, timeout, mfspr_ack}), 32'b100);
            step();
        end
        chk("t6_tmo",   32'({mfspr_ack, timeout, bus.spr_bus_stb_o}), 32'b110);
        chk("t6_dat",   mfspr_dat, 32'd0);
        chk("t6_state", 32'(dbg_state), 32'(OR1K_SPRACC_DONE));
        mfspr = 0;
        step();
        chk("t6_tmo1", 32'(timeout), 32'd0);
`else
        begin
            int drops = 0;
            for (int i = 0; i < 1000; i++) begin
                if (bus.spr_bus_stb_o !== 1'b1 || timeout !== 1'b0 || mfspr_ack !== 1'b0)
                    drops++;
                step();
            end
            chk("t6_stall", 32'(drops), 32'd0);
        end
        chk("t6_state", 32'(dbg_state), 32'(OR1K_SPRACC_ACCESS));
        bus.spr_bus_ack_i = 1; bus.spr_bus_dat_i = 32'h0000_0066;
        step();
        bus.spr_bus_ack_i = 0; mfspr = 0;
        chk("t6_late", 32'({mfspr_ack, timeout}), 32'b10);
        chk("t6_dat",  mfspr_dat, 32'h0000_0066);
        step();
`endif

        // asynchronous reset mid-ACCESS, held op restarts afterwards
        mtspr = 1; alu = 32'h60; rfb = 32'hA5A5_A5A5;
        step();
        chk("t7_pre", 32'(bus.spr_bus_stb_o), 32'd1);
        #2 rst = 1;
        #1;
        chk("t7_stb",   32'({bus.spr_bus_stb_o, bus.spr_bus_we_o}), 32'd0);
        chk("t7_bus",   32'(bus.spr_bus_addr_o) | bus.spr_bus_dat_o, 32'd0);
        chk("t7_out",   32'({mfspr_ack, mtspr_ack, timeout}), 32'd0);
        chk("t7_dat",   mfspr_dat, 32'd0);
        chk("t7_state", 32'(dbg_state), 32'(OR1K_SPRACC_IDLE));
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        step();
        chk("t7_restart", 32'({bus.spr_bus_stb_o, bus.spr_bus_we_o, bus.spr_bus_addr_o}), 32'h3_0060);
        chk("t7_wdat", bus.spr_bus_dat_o, 32'hA5A5_A5A5);
        bus.spr_bus_ack_i = 1;
        step();
        bus.spr_bus_ack_i = 0; mtspr = 0;
        chk("t7_ack", 32'({mfspr_ack, mtspr_ack}), 32'b01);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
